// File: rtl/keystone_coord_engine.sv
// Maps a destination pixel through the latched homography to a rounded source coordinate,
// using a shared iterative restoring divider for the x and y quotients.
module keystone_coord_engine #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned H_W     = 25,
  parameter int unsigned FRAC    = 23,
  parameter int unsigned ACC_W   = 48,
  parameter int unsigned WIDTH   = 1920,
  parameter int unsigned HEIGHT  = 1080,
  parameter int unsigned TAG_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [255:0]       h_regs,
  input  logic               h_load,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [COORD_W-1:0] res_x,
  output logic [COORD_W-1:0] res_y,
  output logic               res_in_bounds,
  output logic [COORD_W-1:0] res_px_x,
  output logic [COORD_W-1:0] res_px_y,
  output logic [TAG_W-1:0]   res_tag
);

  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam logic [255:0] H_IDENT = (256'(1) << FRAC) | (256'(1) << (128 + FRAC));
  localparam logic signed [ACC_W-1:0] W_ONE = ACC_W'(1) << FRAC;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DIV, S_ROUND, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic                      mac_ph_q;
  logic [COORD_W-1:0]        x_q, y_q;
  logic [TAG_W-1:0]          tag_q;
  logic [255:0]              shadow_q, shadow_d, stage_q, stage_d;
  logic                      pend_q, pend_d;
  logic signed [ACC_W-1:0]   xw_q, yw_q, w_q;
  logic [ACC_W-1:0]          rx_q, ry_q;
  logic [ACC_W:0]            qx_q, qy_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [COORD_W-1:0]        res_x_q, res_y_q, res_px_x_q, res_px_y_q;
  logic                      res_ib_q;
  logic [TAG_W-1:0]          res_tag_q;

  function automatic logic [ACC_W-1:0] mag(input logic [ACC_W-1:0] v);
    return v[ACC_W-1] ? (~v + 1'b1) : v;
  endfunction

  // One restoring step: returns {remainder, quotient/dividend shift register}.
  function automatic logic [2*ACC_W:0] div_step(input logic [ACC_W-1:0] rem,
                                                input logic [ACC_W:0] quo,
                                                input logic [ACC_W-1:0] dv);
    logic [ACC_W:0] sh;
    logic           ge;
    sh = {rem, quo[ACC_W]};
    ge = (sh >= {1'b0, dv});
    return {ge ? ACC_W'(sh - {1'b0, dv}) : sh[ACC_W-1:0], quo[ACC_W-1:0], ge};
  endfunction

  logic signed [ACC_W-1:0] ka, kb, kc, kd, ke, kf, kg, kh, xs, ys;
  logic signed [ACC_W-1:0] xw_c, yw_c, w_c;
  logic                    unused_hbits;

  assign ka = ACC_W'($signed(shadow_q[0   +: H_W]));
  assign kb = ACC_W'($signed(shadow_q[32  +: H_W]));
  assign kc = ACC_W'($signed(shadow_q[64  +: 32]));
  assign kd = ACC_W'($signed(shadow_q[96  +: H_W]));
  assign ke = ACC_W'($signed(shadow_q[128 +: H_W]));
  assign kf = ACC_W'($signed(shadow_q[160 +: 32]));
  assign kg = ACC_W'($signed(shadow_q[192 +: H_W]));
  assign kh = ACC_W'($signed(shadow_q[224 +: H_W]));
  // Upper bits of the short coefficient words carry no information.
  assign unused_hbits = ^{shadow_q[H_W +: 32-H_W], shadow_q[32+H_W +: 32-H_W],
                          shadow_q[96+H_W +: 32-H_W], shadow_q[128+H_W +: 32-H_W],
                          shadow_q[192+H_W +: 32-H_W], shadow_q[224+H_W +: 32-H_W]};

  assign xs   = $signed(ACC_W'(x_q));
  assign ys   = $signed(ACC_W'(y_q));
  assign xw_c = ka * xs + kb * ys + kc;
  assign yw_c = kd * xs + ke * ys + kf;
  assign w_c  = kg * xs + kh * ys + W_ONE;

  logic                 w_pos, enter_done;
  logic [ACC_W-1:0]     wmag, rx_in, ry_in, rx_nx, ry_nx;
  logic [ACC_W:0]       qx_in, qy_in, qx_nx, qy_nx, rmx, rmy;
  logic                 ib_x, ib_y;

  assign w_pos = !w_q[ACC_W-1] && (w_q != '0);

  always_comb begin
    wmag = mag(w_q);
    if (state_q == S_MAC) begin
      rx_in = '0;
      ry_in = '0;
      qx_in = {mag(xw_q), 1'b0};
      qy_in = {mag(yw_q), 1'b0};
    end else begin
      rx_in = rx_q;
      ry_in = ry_q;
      qx_in = qx_q;
      qy_in = qy_q;
    end
    {rx_nx, qx_nx} = div_step(rx_in, qx_in, wmag);
    {ry_nx, qy_nx} = div_step(ry_in, qy_in, wmag);
  end

  // Round half away from zero: r = (q + 1) >> 1 on the doubled-dividend quotient.
  always_comb begin
    rmx  = (ACC_W+1)'(({1'b0, qx_q} + (ACC_W+2)'(1)) >> 1);
    rmy  = (ACC_W+1)'(({1'b0, qy_q} + (ACC_W+2)'(1)) >> 1);
    ib_x = (rmx < (ACC_W+1)'(WIDTH))  && (!xw_q[ACC_W-1] || rmx == '0);
    ib_y = (rmy < (ACC_W+1)'(HEIGHT)) && (!yw_q[ACC_W-1] || rmy == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid && req_ready) state_d = S_MAC;
      S_MAC:   if (mac_ph_q) state_d = w_pos ? S_DIV : S_DONE;
      S_DIV:   if (cnt_q == CNT_W'(ACC_W)) state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    stage_d  = stage_q;
    pend_d   = pend_q;
    if (state_q == S_IDLE) begin
      if (h_load) begin
        shadow_d = h_regs;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = stage_q;
        pend_d   = 1'b0;
      end
    end else if (h_load) begin
      stage_d = h_regs;
      pend_d  = 1'b1;
    end
  end

  assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mac_ph_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      tag_q      <= '0;
      shadow_q   <= H_IDENT;
      stage_q    <= '0;
      pend_q     <= 1'b0;
      xw_q       <= '0;
      yw_q       <= '0;
      w_q        <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      cnt_q      <= '0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      res_ib_q   <= 1'b0;
      res_px_x_q <= '0;
      res_px_y_q <= '0;
      res_tag_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      stage_q  <= stage_d;
      pend_q   <= pend_d;
      case (state_q)
        S_IDLE: if (req_valid && req_ready) begin
          x_q      <= req_x;
          y_q      <= req_y;
          tag_q    <= req_tag;
          mac_ph_q <= 1'b0;
        end
        S_MAC: if (!mac_ph_q) begin
          xw_q     <= xw_c;
          yw_q     <= yw_c;
          w_q      <= w_c;
          mac_ph_q <= 1'b1;
        end else if (w_pos) begin
          // The first divide iteration is folded into the decision cycle.
          rx_q  <= rx_nx;
          ry_q  <= ry_nx;
          qx_q  <= qx_nx;
          qy_q  <= qy_nx;
          cnt_q <= CNT_W'(1);
        end else begin
          res_x_q  <= '0;
          res_y_q  <= '0;
          res_ib_q <= 1'b0;
        end
        S_DIV: begin
          rx_q  <= rx_nx;
          ry_q  <= ry_nx;
          qx_q  <= qx_nx;
          qy_q  <= qy_nx;
          cnt_q <= cnt_q + 1'b1;
        end
        S_ROUND: begin
          res_ib_q <= ib_x && ib_y;
          res_x_q  <= (ib_x && ib_y) ? COORD_W'(rmx) : '0;
          res_y_q  <= (ib_x && ib_y) ? COORD_W'(rmy) : '0;
        end
        default: ;
      endcase
      if (enter_done) begin
        res_px_x_q <= x_q;
        res_px_y_q <= y_q;
        res_tag_q  <= tag_q;
      end
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !pend_q;
  assign res_valid     = (state_q == S_DONE);
  assign res_x         = res_x_q;
  assign res_y         = res_y_q;
  assign res_in_bounds = res_ib_q;
  assign res_px_x      = res_px_x_q;
  assign res_px_y      = res_px_y_q;
  assign res_tag       = res_tag_q;

endmodule

// File: tb/tb_keystone_coord_engine.sv
// Self-checking bench for keystone_coord_engine: directed plan cases plus randomized
// transactions checked against an arithmetic homography model.
module tb_keystone_coord_engine;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned H_W     = 25;
  localparam int unsigned FRAC    = 23;
  localparam int unsigned ACC_W   = 48;
  localparam int unsigned WIDTH   = 1920;
  localparam int unsigned HEIGHT  = 1080;
  localparam int unsigned TAG_W   = 8;
  localparam int ONE      = 1 << FRAC;
  localparam int NORM_LAT = ACC_W + 3;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [255:0]       h_regs;
  logic               h_load;
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x, req_y;
  logic [TAG_W-1:0]   req_tag;
  logic               res_valid;
  logic               res_ready;
  logic [COORD_W-1:0] res_x, res_y, res_px_x, res_px_y;
  logic               res_in_bounds;
  logic [TAG_W-1:0]   res_tag;

  int checks = 0;
  int errors = 0;
  logic [255:0] cur_h;

  keystone_coord_engine #(
    .COORD_W(COORD_W), .H_W(H_W), .FRAC(FRAC), .ACC_W(ACC_W),
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .h_regs(h_regs), .h_load(h_load),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_tag(req_tag), .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_in_bounds(res_in_bounds),
    .res_px_x(res_px_x), .res_px_y(res_px_y), .res_tag(res_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_h(input int a, b, c, d, e, f, g, h);
    return {32'(h), 32'(g), 32'(f), 32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic longint coef(input logic [255:0] hr, input int k, input bit full);
    logic [31:0] wd;
    longint      t;
    wd = hr[32*k +: 32];
    if (full) return longint'($signed(wd));
    t = longint'(wd) <<< (64 - H_W);
    return t >>> (64 - H_W);
  endfunction

  function automatic longint wrap_acc(input longint v);
    longint t;
    t = v <<< (64 - ACC_W);
    return t >>> (64 - ACC_W);
  endfunction

  function automatic longint rnd(input longint num, input longint den);
    longint m, q, r;
    m = (num < 0) ? -num : num;
    q = (2 * m) / den;
    r = (q + 1) / 2;
    return (num < 0) ? -r : r;
  endfunction

  task automatic model(input logic [255:0] hr, input int x, input int y,
                       output longint ex, output longint ey, output longint eib, output int elat);
    longint xw, yw, w, rx, ry;
    xw = wrap_acc(coef(hr,0,0) * x + coef(hr,1,0) * y + coef(hr,2,1));
    yw = wrap_acc(coef(hr,3,0) * x + coef(hr,4,0) * y + coef(hr,5,1));
    w  = wrap_acc(coef(hr,6,0) * x + coef(hr,7,0) * y + longint'(ONE));
    if (w <= 0) begin
      ex = 0; ey = 0; eib = 0; elat = 2;
    end else begin
      rx   = rnd(xw, w);
      ry   = rnd(yw, w);
      eib  = (rx >= 0 && rx < longint'(WIDTH) && ry >= 0 && ry < longint'(HEIGHT)) ? 1 : 0;
      ex   = (eib != 0) ? rx : 0;
      ey   = (eib != 0) ? ry : 0;
      elat = NORM_LAT;
    end
  endtask

  task automatic issue(input int x, input int y, input int tag, input bit ld, input logic [255:0] hv);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_x     = COORD_W'(x);
    req_y     = COORD_W'(y);
    req_tag   = TAG_W'(tag);
    if (ld) begin
      h_regs = hv;
      h_load = 1'b1;
    end
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("accept_timeout", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    h_load    = 1'b0;
  endtask

  task automatic load_h(input logic [255:0] v);
    @(negedge clock);
    h_regs = v;
    h_load = 1'b1;
    @(negedge clock);
    h_load = 1'b0;
  endtask

  task automatic collect(input longint ex, input longint ey, input longint eib, input int elat,
                         input int x, input int y, input int tag, input int hold,
                         output longint ox, output longint oy, output longint oib, output int olat);
    int lat;
    lat = 0;
    while (!res_valid && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    olat = lat;
    ox   = longint'(res_x);
    oy   = longint'(res_y);
    oib  = longint'(res_in_bounds);
    chk("latency", lat, elat);
    chk("res_x", res_x, ex);
    chk("res_y", res_y, ey);
    chk("in_bounds", res_in_bounds, eib);
    chk("res_tag", res_tag, tag);
    chk("px_x", res_px_x, x);
    chk("px_y", res_px_y, y);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", res_valid, 1);
      chk("hold_x", res_x, ex);
      chk("hold_y", res_y, ey);
    end
    res_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
  endtask

  task automatic txn(input int x, input int y, input int tag, input int hold,
                     input bit ld, input logic [255:0] hv,
                     output longint ox, output longint oy, output longint oib, output int olat);
    longint ex, ey, eib;
    int     elat;
    if (ld) cur_h = hv;
    model(cur_h, x, y, ex, ey, eib, elat);
    issue(x, y, tag, ld, hv);
    collect(ex, ey, eib, elat, x, y, tag, hold, ox, oy, oib, olat);
  endtask

  function automatic logic [255:0] rand_h();
    int a, b, c, d, e, f, g, h;
    a = ONE + int'($urandom_range(0, 1 << 21)) - (1 << 20);
    b = int'($urandom_range(0, 1 << 21)) - (1 << 20);
    c = (int'($urandom_range(0, 500)) - 250) * ONE + int'($urandom_range(0, ONE - 1));
    d = int'($urandom_range(0, 1 << 21)) - (1 << 20);
    e = ONE + int'($urandom_range(0, 1 << 21)) - (1 << 20);
    f = (int'($urandom_range(0, 500)) - 250) * ONE + int'($urandom_range(0, ONE - 1));
    g = int'($urandom_range(0, 8192)) - 4096;
    h = int'($urandom_range(0, 8192)) - 4096;
    return mk_h(a, b, c, d, e, f, g, h);
  endfunction

  logic [255:0] ident, hv;
  longint ox, oy, oib, ex, ey, eib;
  int     olat, elat;

  initial begin
    ident     = mk_h(ONE, 0, 0, 0, ONE, 0, 0, 0);
    cur_h     = ident;
    reset_n   = 1'b0;
    h_regs    = '0;
    h_load    = 1'b0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_tag   = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_x", res_x, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_in_bounds", res_in_bounds, 0);
    chk("rst_tag", res_tag, 0);
    chk("rst_px_x", res_px_x, 0);
    reset_n = 1'b1;

    // Identity after reset.
    txn(100, 200, 'h5A, 0, 1'b0, ident, ox, oy, oib, olat);
    chk("ident_x", ox, 100);
    chk("ident_y", oy, 200);
    chk("ident_ib", oib, 1);
    chk("ident_lat", olat, 51);

    // Translation c = +10.5, f = -3.0.
    txn(100, 200, 1, 0, 1'b1, mk_h(ONE, 0, 88080384, 0, ONE, -25165824, 0, 0), ox, oy, oib, olat);
    chk("trans_x", ox, 111);
    chk("trans_y", oy, 197);
    chk("trans_ib", oib, 1);

    // Rounding: 0.5 -> 1 and 0.75 -> 1.
    load_h(mk_h(ONE, 0, 0, 0, 0, 0, ONE, 0));
    cur_h = mk_h(ONE, 0, 0, 0, 0, 0, ONE, 0);
    txn(1, 0, 2, 1, 1'b0, ident, ox, oy, oib, olat);
    chk("half_x", ox, 1);
    txn(3, 0, 3, 0, 1'b0, ident, ox, oy, oib, olat);
    chk("three_q_x", ox, 1);

    // w == 0 takes the short path.
    txn(1, 0, 4, 0, 1'b1, mk_h(ONE, 0, 0, 0, 0, 0, -ONE, 0), ox, oy, oib, olat);
    chk("w0_ib", oib, 0);
    chk("w0_x", ox, 0);
    chk("w0_lat", olat, 2);

    // Frame boundaries.
    txn(1919, 1079, 5, 0, 1'b1, ident, ox, oy, oib, olat);
    chk("corner_ib", oib, 1);
    chk("corner_x", ox, 1919);
    txn(1920, 0, 6, 0, 1'b0, ident, ox, oy, oib, olat);
    chk("xedge_ib", oib, 0);
    chk("xedge_x", ox, 0);
    txn(0, 5, 7, 0, 1'b1, mk_h(ONE, 0, -ONE, 0, ONE, 0, 0, 0), ox, oy, oib, olat);
    chk("negx_ib", oib, 0);
    txn(0, 0, 8, 0, 1'b1, mk_h(ONE, 0, -(ONE / 2), 0, ONE, 0, 0, 0), ox, oy, oib, olat);
    chk("neg_half_ib", oib, 0);

    // Load during DIV with backpressure: result keeps the old H.
    load_h(ident);
    cur_h = ident;
    model(cur_h, 7, 9, ex, ey, eib, elat);
    issue(7, 9, 'h33, 1'b0, ident);
    repeat (10) @(negedge clock);
    load_h(mk_h(ONE, 0, 5 * ONE, 0, ONE, 0, 0, 0));
    collect(ex, ey, eib, elat - 12, 7, 9, 'h33, 20, ox, oy, oib, olat);
    chk("bp_x", ox, 7);
    chk("commit_gap", req_ready, 0);
    @(negedge clock);
    chk("commit_done", req_ready, 1);
    cur_h = mk_h(ONE, 0, 5 * ONE, 0, ONE, 0, 0, 0);
    txn(0, 0, 9, 0, 1'b0, ident, ox, oy, oib, olat);
    chk("committed_x", ox, 5);

    // Reset mid-transaction drops the pending load and restores identity.
    issue(50, 60, 10, 1'b0, ident);
    repeat (5) @(negedge clock);
    load_h(mk_h(ONE, 0, 7 * ONE, 0, ONE, 0, 0, 0));
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_ready", req_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);
    chk("postrst_ready", req_ready, 1);
    cur_h = ident;
    txn(100, 200, 11, 0, 1'b0, ident, ox, oy, oib, olat);
    chk("postrst_x", ox, 100);

    // Load on the accept edge applies to that request.
    txn(10, 20, 12, 0, 1'b1, mk_h(ONE, 0, 3 * ONE, 0, ONE, 0, 0, 0), ox, oy, oib, olat);
    chk("same_edge_x", ox, 13);

    for (int n = 0; n < 40; n++) begin
      hv = rand_h();
      txn(int'($urandom_range(0, 2100)), int'($urandom_range(0, 1300)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0), hv, ox, oy, oib, olat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
